// File: rtl/fpu_pkg.sv
// Shared definitions for the custom-format FPU blocks (adder/subtractor, future multiplier).
// Word format: {sign, EXP_W exponent, MAN_W mantissa}, hidden-one normalised, biased exponent.
package fpu_pkg;

  // Add/sub sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_PACK  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Status vector bit positions
  localparam int unsigned STAT_W    = 4;
  localparam int unsigned STAT_OVF  = 3;
  localparam int unsigned STAT_UNF  = 2;
  localparam int unsigned STAT_INX  = 1;
  localparam int unsigned STAT_ZERO = 0;

  // Exponent bias for a given exponent width
  function automatic int unsigned calc_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  // Total word width: sign + exponent + stored mantissa
  function automatic int unsigned word_width(input int unsigned exp_w, input int unsigned man_w);
    return 32'd1 + exp_w + man_w;
  endfunction

endpackage

// File: rtl/fpu_unpack.sv
// Splits an FPU word into its fields and flags a zero operand (exponent field 0).
// Ports: word_i (packed word) -> sign_o, exp_o, man_o, zero_o. Purely combinational.
module fpu_unpack #(
  parameter int unsigned EXP_W = 6,
  parameter int unsigned MAN_W = 25
) (
  input  logic [EXP_W+MAN_W:0] word_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W-1:0]     man_o,
  output logic                 zero_o
);

  assign sign_o = word_i[EXP_W+MAN_W];
  assign exp_o  = word_i[EXP_W+MAN_W-1:MAN_W];
  assign man_o  = word_i[MAN_W-1:0];
  // A zero exponent field means zero regardless of the mantissa bits
  assign zero_o = (exp_o == '0);

endmodule

// File: rtl/fpu_addsub.sv
// Multi-cycle floating-point adder/subtractor with valid/ready handshakes, truncating rounding.
// Ports: clock, reset (async, active-low); in_valid/in_ready, op_sub, op_a_in, op_b_in (operand side);
//        out_valid/out_ready, data_out, status_out {ovf, unf, inexact, zero} (result side).
module fpu_addsub
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 6,
  parameter int unsigned MAN_W = 25,
  parameter int unsigned BIAS  = calc_bias(EXP_W)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 op_sub,
  input  logic [EXP_W+MAN_W:0] op_a_in,
  input  logic [EXP_W+MAN_W:0] op_b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] data_out,
  output logic [STAT_W-1:0]    status_out
);

  localparam int unsigned WORD_W    = word_width(EXP_W, MAN_W);
  localparam int unsigned WORK_W    = MAN_W + 2;        // carry, hidden, mantissa
  localparam int unsigned EXPR_W    = EXP_W + 2;        // signed working exponent
  localparam int unsigned NORM_MAX  = MAN_W + 2;
  localparam int unsigned CNT_W     = $clog2(NORM_MAX + 1);
  localparam int unsigned SHIFT_LIM = MAN_W + 1;
  // Largest biased exponent (all ones) is the overflow threshold
  localparam logic signed [EXPR_W-1:0] EXP_OVF  = EXPR_W'(2 * BIAS + 1);
  localparam logic signed [EXPR_W-1:0] EXP_ZERO = '0;

  // Field split of the live operand buses
  logic             a_sign_c, b_sign_c, a_zero_c, b_zero_c;
  logic [EXP_W-1:0] a_exp_c, b_exp_c;
  logic [MAN_W-1:0] a_man_c, b_man_c;

  fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .word_i(op_a_in), .sign_o(a_sign_c), .exp_o(a_exp_c), .man_o(a_man_c), .zero_o(a_zero_c)
  );
  fpu_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .word_i(op_b_in), .sign_o(b_sign_c), .exp_o(b_exp_c), .man_o(b_man_c), .zero_o(b_zero_c)
  );

  state_t                    state_q;
  logic                      sign_a_q, sign_b_q, zero_a_q, zero_b_q;
  logic [EXP_W-1:0]          exp_a_q, exp_b_q;
  logic [MAN_W-1:0]          man_a_q, man_b_q;
  logic [WORK_W-1:0]         big_q, small_q, work_q;
  logic                      sign_big_q, sign_small_q, sign_q, sticky_q;
  logic signed [EXPR_W-1:0]  exp_q;
  logic [CNT_W-1:0]          cnt_q;

  // Alignment: larger exponent wins, smaller mantissa shifted right with sticky collection
  logic              a_ge_b_c, small_lost_c;
  logic [EXP_W-1:0]  big_exp_c, small_exp_c, diff_c;
  logic [WORK_W-1:0] full_a_c, full_b_c, small_full_c, small_al_c;

  always_comb begin
    full_a_c     = zero_a_q ? '0 : {1'b0, 1'b1, man_a_q};
    full_b_c     = zero_b_q ? '0 : {1'b0, 1'b1, man_b_q};
    a_ge_b_c     = (exp_a_q >= exp_b_q);
    big_exp_c    = a_ge_b_c ? exp_a_q : exp_b_q;
    small_exp_c  = a_ge_b_c ? exp_b_q : exp_a_q;
    small_full_c = a_ge_b_c ? full_b_c : full_a_c;
    diff_c       = big_exp_c - small_exp_c;
    if (32'(diff_c) > SHIFT_LIM) begin
      small_al_c   = '0;
      small_lost_c = |small_full_c;
    end else begin
      small_al_c   = small_full_c >> diff_c;
      small_lost_c = |(small_full_c & ~({WORK_W{1'b1}} << diff_c));
    end
  end

  // Signed-magnitude add; unlike signs subtract smaller from larger, exact cancel gives +0
  logic [WORK_W-1:0] sum_c;
  logic              sum_sign_c;

  always_comb begin
    sum_c      = '0;
    sum_sign_c = 1'b0;
    if (sign_big_q == sign_small_q) begin
      sum_c      = big_q + small_q;
      sum_sign_c = sign_big_q;
    end else if (big_q > small_q) begin
      sum_c      = big_q - small_q;
      sum_sign_c = sign_big_q;
    end else if (small_q > big_q) begin
      sum_c      = small_q - big_q;
      sum_sign_c = sign_small_q;
    end
  end

  // Result packing with truncation; a zero mantissa wins over exponent range checks
  logic [WORD_W-1:0] pack_data_c;
  logic [STAT_W-1:0] pack_stat_c;

  always_comb begin
    pack_data_c           = '0;
    pack_stat_c           = '0;
    pack_stat_c[STAT_INX] = sticky_q;
    if (work_q == '0) begin
      pack_stat_c[STAT_ZERO] = 1'b1;
    end else if (exp_q >= EXP_OVF) begin
      pack_data_c           = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      pack_stat_c[STAT_OVF] = 1'b1;
    end else if (exp_q <= EXP_ZERO) begin
      pack_data_c            = {sign_q, {(EXP_W + MAN_W){1'b0}}};
      pack_stat_c[STAT_UNF]  = 1'b1;
      pack_stat_c[STAT_ZERO] = 1'b1;
    end else begin
      pack_data_c = {sign_q, exp_q[EXP_W-1:0], work_q[MAN_W-1:0]};
    end
  end

  // Sequencer and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      data_out     <= '0;
      status_out   <= '0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      zero_a_q     <= 1'b0;
      zero_b_q     <= 1'b0;
      exp_a_q      <= '0;
      exp_b_q      <= '0;
      man_a_q      <= '0;
      man_b_q      <= '0;
      big_q        <= '0;
      small_q      <= '0;
      work_q       <= '0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      sign_q       <= 1'b0;
      sticky_q     <= 1'b0;
      exp_q        <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            sign_a_q <= a_sign_c;
            sign_b_q <= b_sign_c ^ op_sub;
            zero_a_q <= a_zero_c;
            zero_b_q <= b_zero_c;
            exp_a_q  <= a_exp_c;
            exp_b_q  <= b_exp_c;
            man_a_q  <= a_man_c;
            man_b_q  <= b_man_c;
            in_ready <= 1'b0;
            state_q  <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          big_q        <= a_ge_b_c ? full_a_c : full_b_c;
          small_q      <= small_al_c;
          sign_big_q   <= a_ge_b_c ? sign_a_q : sign_b_q;
          sign_small_q <= a_ge_b_c ? sign_b_q : sign_a_q;
          exp_q        <= {2'b00, big_exp_c};
          sticky_q     <= small_lost_c;
          state_q      <= ST_ADD;
        end
        ST_ADD: begin
          work_q  <= sum_c;
          sign_q  <= sum_sign_c;
          cnt_q   <= '0;
          state_q <= ST_NORM;
        end
        ST_NORM: begin
          if (work_q[WORK_W-1] && (cnt_q < CNT_W'(NORM_MAX))) begin
            work_q   <= work_q >> 1;
            sticky_q <= sticky_q | work_q[0];
            exp_q    <= exp_q + EXPR_W'(1);
            cnt_q    <= cnt_q + CNT_W'(1);
          end else if (!work_q[MAN_W] && (work_q != '0) && (cnt_q < CNT_W'(NORM_MAX))) begin
            work_q <= work_q << 1;
            exp_q  <= exp_q - EXPR_W'(1);
            cnt_q  <= cnt_q + CNT_W'(1);
          end else begin
            state_q <= ST_PACK;
          end
        end
        ST_PACK: begin
          data_out   <= pack_data_c;
          status_out <= pack_stat_c;
          out_valid  <= 1'b1;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          // Result held until taken; one idle cycle follows before the next accept
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_addsub.sv
// Self-checking bench for fpu_addsub: arithmetic reference model plus scoreboarded monitor.
module tb_fpu_addsub;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, op_sub;
  logic [31:0] op_a_in, op_b_in, data_out;
  logic        out_valid, out_ready;
  logic [3:0]  status_out;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  fpu_addsub dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .op_a_in(op_a_in), .op_b_in(op_b_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .status_out(status_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  stat;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  bit   seen_first = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: value = M * 2^(e-bias-25); smaller operand truncated on alignment, result truncated
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       output logic [31:0] d, output logic [3:0] st, output int lat);
    int     ea, eb, ebig, diff, e, msb, n;
    longint ma, mb, mbig, msml, al, r, mag;
    logic   sa, sb, sbig, ssml, sgn, inx;
    sa = a[31];
    sb = b[31] ^ sub;
    ea = int'(a[30:25]);
    eb = int'(b[30:25]);
    ma = (ea == 0) ? 64'sd0 : (64'sd1 <<< 25) + longint'(a[24:0]);
    mb = (eb == 0) ? 64'sd0 : (64'sd1 <<< 25) + longint'(b[24:0]);
    if (ea >= eb) begin
      ebig = ea; diff = ea - eb; mbig = ma; msml = mb; sbig = sa; ssml = sb;
    end else begin
      ebig = eb; diff = eb - ea; mbig = mb; msml = ma; sbig = sb; ssml = sa;
    end
    al  = msml >>> diff;
    inx = ((al <<< diff) != msml);
    r   = (sbig ? -mbig : mbig) + (ssml ? -al : al);
    sgn = (r < 0);
    mag = sgn ? -r : r;
    e   = ebig;
    if (mag == 0) begin
      d   = 32'h0;
      st  = {2'b00, inx, 1'b1};
      lat = 4;
      return;
    end
    msb = 0;
    for (int i = 0; i < 40; i++) if (mag[i]) msb = i;
    if (msb > 25) begin
      inx = inx | mag[0];
      mag = mag >>> 1;
      e   = e + 1;
      n   = 1;
    end else begin
      n   = 25 - msb;
      mag = mag <<< n;
      e   = e - n;
    end
    lat = 4 + n;
    if (e >= 63) begin
      d  = {sgn, 6'h3F, 25'h0};
      st = {1'b1, 1'b0, inx, 1'b0};
    end else if (e <= 0) begin
      d  = {sgn, 31'h0};
      st = {1'b0, 1'b1, inx, 1'b1};
    end else begin
      d  = {sgn, 6'(e), mag[24:0]};
      st = {2'b00, inx, 1'b0};
    end
  endtask

  // Compare process: every cycle a result is presented it must match the scoreboard head
  always @(negedge clock) begin
    if (reset === 1'b1 && out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out_valid actual=1 required=0 data=%h", data_out);
      end else begin
        check("data_out", data_out, sb_q[0].data);
        check("status_out", 32'(status_out), 32'(sb_q[0].stat));
        check("in_ready_while_valid", 32'(in_ready), 32'd0);
        if (!seen_first) begin
          check("latency", 32'(cyc - sb_q[0].acc), 32'(sb_q[0].lat));
          seen_first = 1'b1;
        end
        if (out_ready === 1'b1) begin
          void'(sb_q.pop_front());
          seen_first = 1'b0;
        end
      end
    end
  end

  // Wait for in_ready and present one operand pair; leaves the bus scrambled after accept
  task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           output bit ok);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    ok = (in_ready === 1'b1);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=%b required=1", in_ready);
      return;
    end
    op_a_in  = a;
    op_b_in  = b;
    op_sub   = sub;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    op_a_in  = $urandom;
    op_b_in  = $urandom;
    op_sub   = 1'($urandom);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [31:0] edata, input logic [3:0] estat, input int elat,
                       input int hold);
    bit ok;
    int guard;
    accept_op(a, b, sub, ok);
    if (!ok) return;
    sb_q.push_back('{edata, estat, elat, cyc});
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
    // out_ready while nothing is valid must be ignored
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin
      @(posedge clock); #1;
      guard++;
    end
    if (out_valid !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL result_timeout actual=%b required=1", out_valid);
      return;
    end
    repeat (hold) begin
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("out_valid_after_take", 32'(out_valid), 32'd0);
    check("in_ready_after_take", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] d;
    logic [3:0]  st;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] md, ra, rb;
    logic [3:0]  ms;
    int          ml, ea;
    bit          ok;

    vecs[0]  = '{"one_plus_one",  32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b0000, 5, 0};
    // 1.5 - 1.0 = 0.5
    vecs[1]  = '{"onehalf_minus", 32'h3F000000, 32'h3E000000, 1'b1, 32'h3C000000, 4'b0000, 5, 0};
    vecs[2]  = '{"x_minus_x",     32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'b0001, 4, 0};
    vecs[3]  = '{"overflow",      32'h7C000000, 32'h7C000000, 1'b0, 32'h7E000000, 4'b1000, 5, 0};
    vecs[4]  = '{"underflow",     32'h02000000, 32'h02000001, 1'b1, 32'h80000000, 4'b0101, 29, 0};
    vecs[5]  = '{"inexact_far",   32'h3E000000, 32'h04000000, 1'b0, 32'h3E000000, 4'b0010, 4, 0};
    vecs[6]  = '{"neg_plus_half", 32'hBE000000, 32'h3C000000, 1'b0, 32'hBC000000, 4'b0000, 5, 2};
    vecs[7]  = '{"align_sticky",  32'h3E000000, 32'h3C000001, 1'b0, 32'h3F000000, 4'b0010, 4, 1};
    vecs[8]  = '{"carry_sticky",  32'h3E000001, 32'h3E000000, 1'b0, 32'h40000000, 4'b0010, 5, 0};
    vecs[9]  = '{"zero_plus_one", 32'h00000000, 32'h3E000000, 1'b0, 32'h3E000000, 4'b0000, 4, 0};
    vecs[10] = '{"zero_minus_zero", 32'h80000123, 32'h80000000, 1'b1, 32'h00000000, 4'b0001, 4, 0};
    vecs[11] = '{"max_exp_finite", 32'h7E000000, 32'h3E000000, 1'b0, 32'h7E000000, 4'b1010, 4, 0};
    vecs[12] = '{"handshake_hold", 32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b0000, 5, 10};

    reset     = 1'b0;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    op_a_in   = '0;
    op_b_in   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_data_out", data_out, 32'h0);
    check("reset_status_out", 32'(status_out), 32'h0);
    reset = 1'b1;
    @(posedge clock); #1;

    // Directed vectors: literal expectations pin the model, then drive the DUT
    foreach (vecs[i]) begin
      model(vecs[i].a, vecs[i].b, vecs[i].sub, md, ms, ml);
      check({"model_data_", vecs[i].name}, md, vecs[i].d);
      check({"model_stat_", vecs[i].name}, 32'(ms), 32'(vecs[i].st));
      check({"model_lat_", vecs[i].name}, 32'(ml), 32'(vecs[i].lat));
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].d, vecs[i].st, vecs[i].lat, vecs[i].hold);
    end

    // Model-driven vectors with nearby exponents to exercise cancellation and shifts
    for (int k = 0; k < 10; k++) begin
      ea = int'($urandom_range(1, 60));
      ra = {1'($urandom), 6'(ea), 25'($urandom)};
      rb = {1'($urandom), 6'(ea + int'($urandom_range(0, 2))), 25'($urandom)};
      if (k % 3 == 0) rb[24:12] = ra[24:12];
      model(ra, rb, 1'(k % 2), md, ms, ml);
      do_op(ra, rb, 1'(k % 2), md, ms, ml, k % 3);
    end

    // Reset in the middle of a long normalisation aborts the operation
    accept_op(32'h02000000, 32'h02000001, 1'b1, ok);
    repeat (6) begin
      @(posedge clock); #1;
    end
    #2 reset = 1'b0;
    #1;
    check("midop_reset_in_ready", 32'(in_ready), 32'd1);
    check("midop_reset_out_valid", 32'(out_valid), 32'd0);
    check("midop_reset_data_out", data_out, 32'h0);
    check("midop_reset_status_out", 32'(status_out), 32'h0);
    seen_first = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    check("no_result_after_abort", 32'(out_valid), 32'd0);

    // Recovery after abort
    do_op(vecs[0].a, vecs[0].b, vecs[0].sub, vecs[0].d, vecs[0].st, vecs[0].lat, 0);
    repeat (3) @(posedge clock);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
